f_im_loader: RTL and testbench
==============================

Name: f_im_loader

Overview:
- Writer side of the fetch-stage instruction memory: takes a byte stream (boot/debug link) and fills the IM array with 32-bit instruction words.
- Stream format: a 4-byte big-endian word count N, then N big-endian instruction words.
- Emits one-cycle word-write strobes indexed from word 0, which corresponds to PC_BASE.
- Holds `o_busy` high during the load so the pipeline can be held in reset/stall.

Parameters:
- `IM_DEPTH`, 4096, IM capacity in words.
- `ADDR_W`, 12, word-index width; log2(`IM_DEPTH`), matching pc offset bits [13:2].
- `PC_BASE`, 32'h0000_3000, byte address of word 0; used only for `o_wr_pc`.
- `TIMEOUT`, 1000000, max idle cycles between accepted bytes while loading; 0 disables.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `i_byte_valid`  in  1  stream byte present.
- `i_byte`  in  8  stream byte.
- `o_byte_ready`  out  1  loader can accept a byte.
- `o_we`  out  1  IM word-write strobe, one cycle.
- `o_waddr`  out  `ADDR_W`  IM word index for the write.
- `o_wdata`  out  32  instruction word for the write.
- `o_wr_pc`  out  32  `PC_BASE` + 4*`o_waddr`, for trace.
- `o_words`  out  `ADDR_W`+1  count of words written in the current load.
- `o_busy`  out  1  load in progress.
- `o_done`  out  1  load completed; sticky.
- `o_err`  out  1  load aborted; sticky.

Behaviour:
- Reset (`i_rst_n`=0 at an edge): state IDLE. All outputs and internal registers are 0: `o_byte_ready`, `o_we`, `o_waddr`, `o_wdata`, `o_wr_pc`, `o_words`, `o_busy`, `o_done`, `o_err`, byte counter, length, timer.
  - Reset overrides every other input, including mid-load.
  - No partial word is written on reset.
- Handshake: a byte is accepted at an edge where `i_byte_valid` and `o_byte_ready` are both 1.
  - `o_byte_ready` is 1 only in LEN and DATA, and is never deasserted inside those states.
  - Bytes presented in other states are dropped.
- FSM states: IDLE, LEN, DATA, DONE, ERR.
- IDLE:
  - `i_start` → LEN.
  - On entry to LEN: clear byte counter, length, `o_words`, timer, `o_done` and `o_err`.
- LEN:
  - Shift accepted bytes in MSB-first.
  - On the 4th accepted byte, with assembled length L:
    - L==0 → DONE.
    - L>`IM_DEPTH` → ERR.
    - otherwise latch L → DATA.
  - `o_busy`=1.
- DATA:
  - Shift bytes MSB-first into a 32-bit assembler.
  - The edge accepting each 4th byte sets, for exactly one cycle:
    - `o_we`=1
    - `o_wdata`=assembled word
    - `o_waddr`=`o_words`[`ADDR_W`-1:0]
    - `o_wr_pc` accordingly
    - `o_words` incremented
  - If the incremented count equals L, the same edge enters DONE, so `o_we` and `o_done` are both high in that cycle.
  - Back-to-back bytes are allowed with no bubbles: a write strobe never stalls acceptance.
  - `o_busy`=1.
- DONE: `o_done`=1, `o_busy`=0, `o_byte_ready`=0. `i_start` → LEN.
- ERR: `o_err`=1, `o_busy`=0, `o_byte_ready`=0. `i_start` → LEN.
- `i_start` while in LEN or DATA is ignored.
- `o_waddr` and `o_wdata` hold their last values when `o_we`=0.
- Timeout: in LEN and DATA, the timer counts cycles with no accepted byte and clears on each acceptance.
  - When the timer reaches `TIMEOUT` (≠0), go to ERR.
  - Words already written stay written; `o_words` is retained.
- Length check is unsigned 32-bit. `o_words` never exceeds `IM_DEPTH`, so the index cannot wrap.

Test Plan:
1. After reset, `i_start`, then bytes 00 00 00 02 12 34 56 78 9A BC DE F0 back-to-back → two write strobes:
   - `o_we` one cycle after the 8th byte edge region: addr 0, data 32'h12345678, `o_wr_pc` 32'h3000.
   - addr 1, data 32'h9ABCDEF0, `o_wr_pc` 32'h3004, with `o_done`=1 in the same cycle.
   - Final state: `o_words`=2, `o_busy`=0.
2. Same stream with 0–3 idle cycles of `i_byte_valid` between bytes; bytes also driven before `i_start` → identical writes; pre-start bytes ignored; `o_byte_ready`=0 in IDLE and DONE.
3. Length 00 00 00 00 → DONE on the 4th byte, no `o_we`, `o_words`=0. Length 00 00 10 01 (4097) → `o_err`=1, `o_byte_ready`=0, no writes.
4. `TIMEOUT`=16, stream 00 00 00 03 AA BB CC DD EE then silence → one write (addr 0, 32'hAABBCCDD), `o_err` after 16 idle cycles, `o_words`=1. Then `i_start` plus a full valid stream → `o_err` clears, load succeeds.
5. `i_rst_n` low for one edge after 6 DATA bytes → every output 0, state IDLE, no strobe for the partial word. Re-start and reload → writes begin again at addr 0.
6. `i_start` pulsed mid-DATA → ignored; load continues and completes normally.

Source files
------------

// File: rtl/f_im_loader.sv
// f_im_loader: writer side of the instruction memory.
// Consumes a byte stream (4-byte big-endian word count N, then N big-endian
// words) and issues one-cycle word-write strobes starting at word index 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | after reset, waiting for i_start
// S_LEN  | assembling the 32-bit word count
// S_DATA | assembling instruction words, one write per 4 bytes
// S_DONE | all N words written (sticky until the next i_start)
// S_ERR  | bad length or idle timeout (sticky until the next i_start)
module f_im_loader #(
    parameter int unsigned IM_DEPTH = 4096,
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] PC_BASE  = 32'h0000_3000,
    parameter int unsigned TIMEOUT  = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [31:0]       o_wdata,
    output logic [31:0]       o_wr_pc,
    output logic [ADDR_W:0]   o_words,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_bcnt;
    logic [31:0]       r_len;
    logic [23:0]       r_asm;
    logic [31:0]       r_timer;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_wr_pc;
    logic [ADDR_W:0]   r_words;

    logic              w_accept;
    logic              w_last_byte;
    logic [31:0]       w_len_full;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_words_inc;
    logic              w_load_done;
    logic              w_timeout;
    logic              w_enter_len;

    assign w_accept    = i_byte_valid && o_byte_ready;
    assign w_last_byte = (r_bcnt == 2'd3);
    assign w_len_full  = {r_len[23:0], i_byte};
    assign w_word      = {r_asm, i_byte};
    assign w_words_inc = r_words + (ADDR_W+1)'(1);
    assign w_load_done = (32'(w_words_inc) == r_len);
    // The timer holds the idle count before this edge; firing on count+1
    // gives exactly TIMEOUT idle edges before the abort.
    assign w_timeout   = (TIMEOUT != 0) && ((r_timer + 32'd1) == TIMEOUT);
    assign w_enter_len = (w_next == S_LEN) && (r_state != S_LEN);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_next       = r_state;
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LEN;
            end
            S_LEN: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (w_accept) begin
                    if (w_last_byte) begin
                        if (w_len_full == 32'd0)          w_next = S_DONE;
                        else if (w_len_full > IM_DEPTH)   w_next = S_ERR;
                        else                              w_next = S_DATA;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (w_accept) begin
                    if (w_last_byte && w_load_done) w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) w_next = S_LEN;
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_start) w_next = S_LEN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Byte assembly, idle timer and the registered write port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bcnt  <= '0;
            r_len   <= '0;
            r_asm   <= '0;
            r_timer <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wr_pc <= '0;
            r_words <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_enter_len) begin
                r_bcnt  <= '0;
                r_len   <= '0;
                r_asm   <= '0;
                r_timer <= '0;
                r_words <= '0;
            end else if (r_state == S_LEN || r_state == S_DATA) begin
                if (w_accept) begin
                    r_timer <= '0;
                    r_bcnt  <= r_bcnt + 2'd1;
                    if (r_state == S_LEN) begin
                        r_len <= w_len_full;
                    end else begin
                        r_asm <= w_word[23:0];
                        if (w_last_byte) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                            r_waddr <= r_words[ADDR_W-1:0];
                            r_wr_pc <= PC_BASE + (32'(r_words[ADDR_W-1:0]) << 2);
                            r_words <= w_words_inc;
                        end
                    end
                end else begin
                    r_timer <= r_timer + 32'd1;
                end
            end
        end
    end

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_wr_pc = r_wr_pc;
    assign o_words = r_words;

endmodule

// File: tb/tb_f_im_loader.sv
// Testbench for f_im_loader: directed streams, a stream-level expectation
// model driven alongside the stimulus, and a per-cycle compare process.
module tb_f_im_loader;

    localparam int ADDR_W = 12;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic              i_byte_valid = 1'b0;
    logic [7:0]        i_byte = 8'h00;
    logic              o_byte_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [31:0]       o_wdata;
    logic [31:0]       o_wr_pc;
    logic [ADDR_W:0]   o_words;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    f_im_loader #(
        .IM_DEPTH (4096),
        .ADDR_W   (ADDR_W),
        .PC_BASE  (32'h0000_3000),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_wr_pc      (o_wr_pc),
        .o_words      (o_words),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // expected status as seen between edges
    bit        exp_loading = 1'b0;
    bit        exp_done    = 1'b0;
    bit        exp_err     = 1'b0;
    int        exp_words   = 0;

    typedef struct {
        int          due;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;
    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } seen_t;

    wr_t   expq[$];
    seen_t seen_q[$];
    logic [7:0] strm [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Per-cycle compare against the expectation model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() != 0 && expq[0].due == cyc) begin
                chk("we_strobe", 32'(o_we), 32'd1);
                chk("waddr", 32'(o_waddr), 32'(expq[0].addr));
                chk("wdata", o_wdata, expq[0].data);
                chk("wr_pc", o_wr_pc, expq[0].pc);
                expq.delete(0);
            end else begin
                chk("we_quiet", 32'(o_we), 32'd0);
            end
            if (o_we) seen_q.push_back('{o_waddr, o_wdata});
            chk("ready", 32'(o_byte_ready), 32'(exp_loading));
            chk("busy",  32'(o_busy),       32'(exp_loading));
            chk("done",  32'(o_done),       32'(exp_done));
            chk("err",   32'(o_err),        32'(exp_err));
            chk("words", 32'(o_words),      32'(exp_words));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_stream(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) strm[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        repeat (edges) tick();
        exp_loading = 1'b0;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_words   = 0;
        expq.delete();
        i_rst_n = 1'b1;
    endtask

    task automatic start_load;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        exp_loading = 1'b1;
        exp_done    = 1'b0;
        exp_err     = 1'b0;
        exp_words   = 0;
        seen_q.delete();
    endtask

    // Bytes presented while not loading; they must have no effect.
    task automatic drive_junk(input int n);
        for (int i = 0; i < n; i++) begin
            i_byte_valid = 1'b1;
            i_byte = 8'hA5 ^ 8'(i);
            tick();
        end
        i_byte_valid = 1'b0;
    endtask

    // Drive up to nbytes of strm; every byte sent while loading is accepted.
    // Expected writes come straight from the stream layout: the count is
    // bytes 0..3, word w is bytes 4+4w..7+4w, each written one cycle after
    // the edge that takes its last byte.
    task automatic run_stream(input int nbytes, input bit gaps, input int start_at);
        logic [31:0] len;
        int w;
        len = 32'd0;
        for (int k = 0; k < nbytes; k++) begin
            if (!exp_loading) break;
            if (gaps) repeat (k % 4) tick();
            i_byte_valid = 1'b1;
            i_byte = strm[k];
            i_start = (k == start_at);
            tick();
            i_byte_valid = 1'b0;
            i_start = 1'b0;
            if (k == 3) begin
                len = {strm[0], strm[1], strm[2], strm[3]};
                if (len == 32'd0) begin
                    exp_loading = 1'b0;
                    exp_done = 1'b1;
                end else if (len > 32'd4096) begin
                    exp_loading = 1'b0;
                    exp_err = 1'b1;
                end
            end else if (k > 3 && ((k - 4) % 4) == 3) begin
                w = (k - 4) / 4;
                expq.push_back('{cyc, 12'(w),
                                 {strm[k-3], strm[k-2], strm[k-1], strm[k]},
                                 32'h0000_3000 + 32'(4 * w)});
                exp_words = w + 1;
                if (32'(w + 1) == len) begin
                    exp_loading = 1'b0;
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    logic [127:0] s_two;

    initial begin
        s_two = 128'h00000002_12345678_9ABCDEF0;

        // reset state
        do_reset(2);
        chk("rst_ready", 32'(o_byte_ready), 32'd0);
        chk("rst_we",    32'(o_we),         32'd0);
        chk("rst_waddr", 32'(o_waddr),      32'd0);
        chk("rst_wdata", o_wdata,           32'd0);
        chk("rst_wr_pc", o_wr_pc,           32'd0);
        chk("rst_words", 32'(o_words),      32'd0);
        chk("rst_busy",  32'(o_busy),       32'd0);
        chk("rst_done",  32'(o_done),       32'd0);
        chk("rst_err",   32'(o_err),        32'd0);
        chk_en = 1'b1;

        // 1: back-to-back two-word load
        start_load();
        set_stream(s_two, 12);
        run_stream(12, 1'b0, -1);
        drive_junk(2);
        repeat (2) tick();
        chk("t1_nwr", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() >= 1) begin
            chk("t1_w0_addr", 32'(seen_q[0].addr), 32'd0);
            chk("t1_w0_data", seen_q[0].data, 32'h12345678);
        end
        chk("t1_waddr", 32'(o_waddr), 32'd1);
        chk("t1_wdata", o_wdata, 32'h9ABCDEF0);
        chk("t1_wr_pc", o_wr_pc, 32'h0000_3004);
        chk("t1_words", 32'(o_words), 32'd2);
        chk("t1_busy",  32'(o_busy), 32'd0);
        chk("t1_done",  32'(o_done), 32'd1);

        // 2: pre-start bytes ignored, gapped stream
        do_reset(1);
        drive_junk(3);
        start_load();
        set_stream(s_two, 12);
        run_stream(12, 1'b1, -1);
        repeat (2) tick();
        chk("t2_nwr", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() >= 2) begin
            chk("t2_w1_addr", 32'(seen_q[1].addr), 32'd1);
            chk("t2_w1_data", seen_q[1].data, 32'h9ABCDEF0);
        end
        chk("t2_words", 32'(o_words), 32'd2);

        // 3a: zero length
        start_load();
        set_stream(128'h00000000, 4);
        run_stream(4, 1'b0, -1);
        repeat (3) tick();
        chk("t3a_nwr",  32'(seen_q.size()), 32'd0);
        chk("t3a_done", 32'(o_done), 32'd1);
        chk("t3a_words", 32'(o_words), 32'd0);

        // 3b: length 4097 rejected; following bytes dropped
        start_load();
        set_stream(128'h00001001, 4);
        run_stream(4, 1'b0, -1);
        drive_junk(4);
        chk("t3b_nwr",   32'(seen_q.size()), 32'd0);
        chk("t3b_err",   32'(o_err), 32'd1);
        chk("t3b_ready", 32'(o_byte_ready), 32'd0);

        // 4: timeout after one word, then a clean reload
        start_load();
        set_stream(128'h00000003_AABBCCDD_EE, 9);
        run_stream(9, 1'b0, -1);
        repeat (TO) tick();
        exp_loading = 1'b0;
        exp_err = 1'b1;
        tick();
        chk("t4_nwr", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() >= 1) begin
            chk("t4_w0_addr", 32'(seen_q[0].addr), 32'd0);
            chk("t4_w0_data", seen_q[0].data, 32'hAABBCCDD);
        end
        chk("t4_err",   32'(o_err), 32'd1);
        chk("t4_words", 32'(o_words), 32'd1);
        start_load();
        set_stream(s_two, 12);
        run_stream(12, 1'b0, -1);
        tick();
        chk("t4r_err",   32'(o_err), 32'd0);
        chk("t4r_done",  32'(o_done), 32'd1);
        chk("t4r_words", 32'(o_words), 32'd2);

        // 5: reset mid-DATA, then reload from word 0
        start_load();
        set_stream(s_two, 12);
        run_stream(10, 1'b0, -1);
        tick();
        do_reset(1);
        chk("t5_wdata", o_wdata, 32'd0);
        chk("t5_wr_pc", o_wr_pc, 32'd0);
        chk("t5_words", 32'(o_words), 32'd0);
        chk("t5_busy",  32'(o_busy), 32'd0);
        repeat (2) tick();
        chk("t5_nwr_pre", 32'(seen_q.size()), 32'd1);
        start_load();
        run_stream(12, 1'b0, -1);
        tick();
        chk("t5_nwr", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() >= 1) begin
            chk("t5_w0_addr", 32'(seen_q[0].addr), 32'd0);
            chk("t5_w0_data", seen_q[0].data, 32'h12345678);
        end

        // 6: i_start during DATA is ignored
        start_load();
        set_stream(s_two, 12);
        run_stream(12, 1'b0, 6);
        tick();
        chk("t6_nwr",   32'(seen_q.size()), 32'd2);
        chk("t6_done",  32'(o_done), 32'd1);
        chk("t6_words", 32'(o_words), 32'd2);

        chk("pending_writes", 32'(expq.size()), 32'd0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
